shell_reset_sequencer: RTL and testbench

- Brings up the shell after configuration: waits for the clock PLL to lock, resets the DDR4 controller, waits for memory calibration, waits for the GT link to come up, then releases the application reset.
- Sits between the shell's clock/IP status signals (PLL, DDR4 controller, GT core) and the application-side reset it drives.
- Monitors all status inputs while running and re-sequences on any loss.
- Stops in a sticky FAIL state after repeated calibration or link timeouts.

---
 rtl/shell_reset_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_shell_reset_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shell_reset_sequencer.sv
// shell_reset_sequencer
// Post-configuration bring-up sequencer for the shell: waits for PLL lock,
// pulses the DDR4 controller reset, waits for calibration, waits for the GT
// link, then releases the active-low application reset. Any loss of a status
// input while running re-sequences; repeated timeouts park the block in a
// sticky FAIL state that only rst can leave.
//
// Build option: define SHELL_RST_SYNC_INPUTS_EN to pass pll_locked,
// ddr_calib_complete and gt_channel_up through two-flop synchronizers
// (adds two cycles of latency to every input-driven transition). Left
// undefined, the inputs must already be synchronous to CLK.
module shell_reset_sequencer #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int MAX_RETRY      = 3
) (
    input  logic                                 CLK,
    input  logic                                 rst,
    input  logic                                 pll_locked,
    input  logic                                 ddr_calib_complete,
    input  logic                                 gt_channel_up,
    output logic                                 ddr_sys_rst,
    output logic                                 gt_reset,
    output logic                                 rstn,
    output logic                                 ready,
    output logic                                 error,
    output logic [2:0]                           state,
    output logic [$clog2(MAX_RETRY+1)-1:0]       retry_count
);

    localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_PLL_WAIT = 3'd1,
        S_DDR_RST  = 3'd2,
        S_DDR_CAL  = 3'd3,
        S_GT_WAIT  = 3'd4,
        S_RUN      = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    // Saturating increments: counters stop at all-ones and never wrap.
    function automatic logic [STAB_W-1:0] stab_sat_inc(input logic [STAB_W-1:0] v);
        return (v == {STAB_W{1'b1}}) ? v : v + STAB_W'(1);
    endfunction

    function automatic logic [TMO_W-1:0] tmo_sat_inc(input logic [TMO_W-1:0] v);
        return (v == {TMO_W{1'b1}}) ? v : v + TMO_W'(1);
    endfunction

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + HOLD_W'(1);
    endfunction

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

    // Status inputs as seen by the FSM (optionally synchronized)
    logic pll_s;
    logic cal_s;
    logic chan_s;

`ifdef SHELL_RST_SYNC_INPUTS_EN
    logic [1:0] pll_sync;
    logic [1:0] cal_sync;
    logic [1:0] chan_sync;

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge CLK) begin
        if (rst) begin
            pll_sync  <= 2'b00;
            cal_sync  <= 2'b00;
            chan_sync <= 2'b00;
        end else begin
            pll_sync  <= {pll_sync[0], pll_locked};
            cal_sync  <= {cal_sync[0], ddr_calib_complete};
            chan_sync <= {chan_sync[0], gt_channel_up};
        end
    end

    assign pll_s  = pll_sync[1];
    assign cal_s  = cal_sync[1];
    assign chan_s = chan_sync[1];
`else
    assign pll_s  = pll_locked;
    assign cal_s  = ddr_calib_complete;
    assign chan_s = gt_channel_up;
`endif

    state_t              state_q;
    state_t              state_nxt;
    logic [STAB_W-1:0]   stab_q;
    logic [STAB_W-1:0]   stab_nxt;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_nxt;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [RETRY_W-1:0]  retry_q;
    logic [RETRY_W-1:0]  retry_nxt;
    logic [RETRY_W-1:0]  retry_inc;
    logic                timeout;

    logic                ddr_sys_rst_nxt;
    logic                gt_reset_nxt;
    logic                rstn_nxt;
    logic                ready_nxt;
    logic                error_nxt;

    // Next-state, counter and output decode; outputs follow the next state so
    // that the registered outputs always match the registered state.
    always_comb begin
        state_nxt = state_q;
        stab_nxt  = stab_q;
        tmo_nxt   = tmo_q;
        hold_nxt  = hold_q;
        retry_nxt = retry_q;
        retry_inc = retry_sat_inc(retry_q);
        timeout   = 1'b0;

        case (state_q)
            S_RESET: begin
                state_nxt = S_PLL_WAIT;
            end

            S_PLL_WAIT: begin
                if (!pll_s) begin
                    stab_nxt = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_nxt = S_DDR_RST;
                end else begin
                    stab_nxt = stab_sat_inc(stab_q);
                end
            end

            S_DDR_RST: begin
                if (!pll_s) begin
                    state_nxt = S_PLL_WAIT;
                end else if (hold_q == HOLD_LAST) begin
                    state_nxt = S_DDR_CAL;
                end else begin
                    hold_nxt = hold_sat_inc(hold_q);
                end
            end

            S_DDR_CAL: begin
                if (!pll_s) begin
                    state_nxt = S_PLL_WAIT;
                end else if (cal_s) begin
                    state_nxt = S_GT_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    tmo_nxt = tmo_sat_inc(tmo_q);
                end
            end

            S_GT_WAIT: begin
                if (!pll_s) begin
                    state_nxt = S_PLL_WAIT;
                end else if (!cal_s) begin
                    // Calibration lost: redo the DDR reset, not a timeout
                    state_nxt = S_DDR_RST;
                end else if (chan_s && (stab_q == STAB_LAST)) begin
                    state_nxt = S_RUN;
                end else begin
                    stab_nxt = chan_s ? stab_sat_inc(stab_q) : '0;
                    if (tmo_q == TMO_LAST) begin
                        timeout = 1'b1;
                    end else begin
                        tmo_nxt = tmo_sat_inc(tmo_q);
                    end
                end
            end

            S_RUN: begin
                if (!pll_s) begin
                    state_nxt = S_PLL_WAIT;
                end else if (!cal_s || !chan_s) begin
                    state_nxt = S_DDR_RST;
                end
            end

            S_FAIL: begin
                // Absorbing; only rst leaves
                state_nxt = S_FAIL;
            end

            default: begin
                state_nxt = S_RESET;
            end
        endcase

        if (timeout) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RETRY_MAX) ? S_FAIL : S_DDR_RST;
        end

        if (state_nxt != state_q) begin
            stab_nxt = '0;
            tmo_nxt  = '0;
            hold_nxt = '0;
        end

        if ((state_nxt == S_RUN) && (state_q != S_RUN)) begin
            retry_nxt = '0;
        end

        ddr_sys_rst_nxt = (state_nxt == S_RESET)    || (state_nxt == S_PLL_WAIT) ||
                          (state_nxt == S_DDR_RST)  || (state_nxt == S_FAIL);
        gt_reset_nxt    = !((state_nxt == S_GT_WAIT) || (state_nxt == S_RUN));
        rstn_nxt        = (state_nxt == S_RUN);
        ready_nxt       = (state_nxt == S_RUN);
        error_nxt       = (state_nxt == S_FAIL);
    end

    // State, counter and output registers
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= S_RESET;
            stab_q      <= '0;
            tmo_q       <= '0;
            hold_q      <= '0;
            retry_q     <= '0;
            ddr_sys_rst <= 1'b1;
            gt_reset    <= 1'b1;
            rstn        <= 1'b0;
            ready       <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            stab_q      <= stab_nxt;
            tmo_q       <= tmo_nxt;
            hold_q      <= hold_nxt;
            retry_q     <= retry_nxt;
            ddr_sys_rst <= ddr_sys_rst_nxt;
            gt_reset    <= gt_reset_nxt;
            rstn        <= rstn_nxt;
            ready       <= ready_nxt;
            error       <= error_nxt;
        end
    end

    assign state       = state_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_shell_reset_sequencer.sv
// Directed bench for shell_reset_sequencer with small parameters
// (STABLE=4, HOLD=3, TIMEOUT=20, MAX_RETRY=2).
module tb_shell_reset_sequencer;

    localparam int STABLE = 4;
    localparam int HOLD   = 3;
    localparam int TMO    = 20;
    localparam int MAXR   = 2;

    logic       CLK = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       ddr_calib_complete;
    logic       gt_channel_up;
    logic       ddr_sys_rst;
    logic       gt_reset;
    logic       rstn;
    logic       ready;
    logic       error;
    logic [2:0] state;
    logic [1:0] retry_count;

    // {state, ddr_sys_rst, gt_reset, rstn, ready, error, retry_count}
    wire  [9:0] outs = {state, ddr_sys_rst, gt_reset, rstn, ready, error, retry_count};

    int tests_run    = 0;
    int tests_failed = 0;

    shell_reset_sequencer #(
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (MAXR)
    ) dut (
        .CLK               (CLK),
        .rst               (rst),
        .pll_locked        (pll_locked),
        .ddr_calib_complete(ddr_calib_complete),
        .gt_channel_up     (gt_channel_up),
        .ddr_sys_rst       (ddr_sys_rst),
        .gt_reset          (gt_reset),
        .rstn              (rstn),
        .ready             (ready),
        .error             (error),
        .state             (state),
        .retry_count       (retry_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        rst                = 1'b1;
        pll_locked         = 1'b0;
        ddr_calib_complete = 1'b0;
        gt_channel_up      = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (state == s) ok = 1'b1;
    endtask

    task automatic count_state(input logic [2:0] s, input int bound, output int n);
        n = 0;
        while ((state == s) && (n < bound)) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (outs !== {3'd0, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected %b", outs, {3'd0, 5'b11000, 2'd0});
        end
    endtask

    task automatic test_nominal();
        int n;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b0;
        tick();
        tests_run++;
        if (outs !== {3'd1, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL nominal_pll_wait_entry: got %b expected %b", outs, {3'd1, 5'b11000, 2'd0});
        end
        count_state(3'd1, 50, n);
        tests_run++;
        if (n !== STABLE) begin
            tests_failed++;
            $display("FAIL nominal_pll_wait_len: got %0d expected %0d", n, STABLE);
        end
        tests_run++;
        if (outs !== {3'd2, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL nominal_ddr_rst_entry: got %b expected %b", outs, {3'd2, 5'b11000, 2'd0});
        end
        count_state(3'd2, 50, n);
        tests_run++;
        if (n !== HOLD) begin
            tests_failed++;
            $display("FAIL nominal_ddr_rst_len: got %0d expected %0d", n, HOLD);
        end
        tests_run++;
        if (outs !== {3'd3, 5'b01000, 2'd0}) begin
            tests_failed++;
            $display("FAIL nominal_ddr_cal_entry: got %b expected %b", outs, {3'd3, 5'b01000, 2'd0});
        end
        repeat (10) tick();
        tests_run++;
        if (state !== 3'd3) begin
            tests_failed++;
            $display("FAIL nominal_cal_wait: got %0d expected %0d", state, 3);
        end
        ddr_calib_complete = 1'b1;
        tick();
        tests_run++;
        if (outs !== {3'd4, 5'b00000, 2'd0}) begin
            tests_failed++;
            $display("FAIL nominal_gt_wait_entry: got %b expected %b", outs, {3'd4, 5'b00000, 2'd0});
        end
        n = 0;
        while (!rstn && (n < 50)) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== STABLE) begin
            tests_failed++;
            $display("FAIL nominal_rstn_delay: got %0d expected %0d", n, STABLE);
        end
        tests_run++;
        if (outs !== {3'd5, 5'b00110, 2'd0}) begin
            tests_failed++;
            $display("FAIL nominal_run: got %b expected %b", outs, {3'd5, 5'b00110, 2'd0});
        end
    endtask

    task automatic test_pll_glitch();
        int n;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b0;
        tick();
        n = 0;
        while ((state == 3'd1) && (n < 50)) begin
            n++;
            // cycles 1-3 high, cycle 4 low, then high again
            pll_locked = (n == 4) ? 1'b0 : 1'b1;
            tick();
        end
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL pll_glitch_len: got %0d expected %0d", n, 8);
        end
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("FAIL pll_glitch_next: got %0d expected %0d", state, 2);
        end
    endtask

    task automatic test_cal_timeout();
        int n;
        bit ok;
        bit stay;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b0;
        wait_state(3'd3, 50, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL cal_timeout_reach_cal: got state %0d expected %0d", state, 3);
        end
        count_state(3'd3, 100, n);
        tests_run++;
        if (n !== TMO) begin
            tests_failed++;
            $display("FAIL cal_timeout_len1: got %0d expected %0d", n, TMO);
        end
        tests_run++;
        if (outs !== {3'd2, 5'b11000, 2'd1}) begin
            tests_failed++;
            $display("FAIL cal_timeout_retry1: got %b expected %b", outs, {3'd2, 5'b11000, 2'd1});
        end
        wait_state(3'd3, 50, ok);
        count_state(3'd3, 100, n);
        tests_run++;
        if (n !== TMO) begin
            tests_failed++;
            $display("FAIL cal_timeout_len2: got %0d expected %0d", n, TMO);
        end
        tests_run++;
        if (outs !== {3'd6, 5'b11001, 2'd2}) begin
            tests_failed++;
            $display("FAIL cal_timeout_fail_state: got %b expected %b", outs, {3'd6, 5'b11001, 2'd2});
        end
        pll_locked = 1'b0; ddr_calib_complete = 1'b1; gt_channel_up = 1'b0;
        stay = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pll_locked = i[0];
            tick();
            if ((state !== 3'd6) || (error !== 1'b1)) stay = 1'b0;
        end
        tests_run++;
        if (stay !== 1'b1) begin
            tests_failed++;
            $display("FAIL fail_sticky: got state %0d error %0b expected state 6 error 1", state, error);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (outs !== {3'd0, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL fail_exit_by_rst: got %b expected %b", outs, {3'd0, 5'b11000, 2'd0});
        end
    endtask

    task automatic test_retry_clear();
        bit ok;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b0;
        wait_state(3'd3, 50, ok);
        tick();
        wait_state(3'd2, 50, ok);
        tests_run++;
        if (retry_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL retry_after_timeout: got %0d expected %0d", retry_count, 1);
        end
        ddr_calib_complete = 1'b1;
        wait_state(3'd5, 100, ok);
        tests_run++;
        if (!ok || (retry_count !== 2'd0)) begin
            tests_failed++;
            $display("FAIL retry_clear_on_run: got state %0d retry %0d expected state 5 retry 0", state, retry_count);
        end
    endtask

    task automatic test_link_loss();
        bit ok;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b1;
        wait_state(3'd5, 100, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL link_loss_reach_run: got state %0d expected %0d", state, 5);
        end
        gt_channel_up = 1'b0;
        tick();
        gt_channel_up = 1'b1;
        tests_run++;
        if (outs !== {3'd2, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL link_loss_drop: got %b expected %b", outs, {3'd2, 5'b11000, 2'd0});
        end
        wait_state(3'd5, 100, ok);
        tests_run++;
        if (!ok || (outs !== {3'd5, 5'b00110, 2'd0})) begin
            tests_failed++;
            $display("FAIL link_loss_recover: got %b expected %b", outs, {3'd5, 5'b00110, 2'd0});
        end
    endtask

    task automatic test_pll_priority();
        bit ok;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b0;
        wait_state(3'd3, 50, ok);
        repeat (TMO - 1) tick();
        tests_run++;
        if (state !== 3'd3) begin
            tests_failed++;
            $display("FAIL pll_prio_still_cal: got %0d expected %0d", state, 3);
        end
        pll_locked = 1'b0;
        tick();
        tests_run++;
        if (outs !== {3'd1, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL pll_prio_over_timeout: got %b expected %b", outs, {3'd1, 5'b11000, 2'd0});
        end
    endtask

    task automatic test_rst_in_run();
        bit ok;
        apply_reset();
        rst = 1'b0; pll_locked = 1'b1; gt_channel_up = 1'b1; ddr_calib_complete = 1'b1;
        wait_state(3'd5, 100, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rst_run_reach_run: got state %0d expected %0d", state, 5);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (outs !== {3'd0, 5'b11000, 2'd0}) begin
            tests_failed++;
            $display("FAIL rst_in_run: got %b expected %b", outs, {3'd0, 5'b11000, 2'd0});
        end
        wait_state(3'd5, 100, ok);
        tests_run++;
        if (!ok || (ready !== 1'b1)) begin
            tests_failed++;
            $display("FAIL rst_resequence: got state %0d ready %0b expected state 5 ready 1", state, ready);
        end
    endtask

    initial begin
        rst                = 1'b1;
        pll_locked         = 1'b0;
        ddr_calib_complete = 1'b0;
        gt_channel_up      = 1'b0;
        test_reset();
        test_nominal();
        test_pll_glitch();
        test_cal_timeout();
        test_retry_clear();
        test_link_loss();
        test_pll_priority();
        test_rst_in_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
